// File: rtl/sramc_top.sv
// AHB-Lite zero-wait-state SRAM slave: eight byte-wide banks in two groups,
// with a march-style BIST engine and a DFT bypass that blocks bus access.
module sramc_top #(
  parameter int ADDR_W = 13
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic        hwrite,
  input  logic        hready,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic        dft_en,
  input  logic        bist_en,
  output logic        hready_resp,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic        bist_done,
  output logic [7:0]  bist_fail
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_W55  = 3'd1;
  localparam logic [2:0] S_R55  = 3'd2;
  localparam logic [2:0] S_WAA  = 3'd3;
  localparam logic [2:0] S_RAA  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [7:0]        bank [8][DEPTH];
  logic [2:0]        state;
  logic [ADDR_W-1:0] brow;
  logic [15:0]       addr_q;
  logic [2:0]        size_q;
  logic              wr_q;
  logic              rd_q;
  logic              idle;
  logic              accept;
  logic              grp;
  logic [ADDR_W-1:0] row;
  logic [3:0]        lane_en;
  logic [31:0]       rd_word;
  logic              bist_wr;
  logic              bist_rd;
  logic [7:0]        bist_pat;
  logic [7:0]        mism;
  logic              unused;

  assign unused = ^{hburst, haddr[31:16], htrans[0], addr_q};

  assign idle   = (state == S_IDLE);
  assign accept = hsel & hready & htrans[1] & ~dft_en & idle;

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      addr_q <= '0;
      size_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      wr_q <= accept & hwrite;
      rd_q <= accept & ~hwrite;
      if (accept) begin
        addr_q <= haddr[15:0];
        size_q <= hsize;
      end
    end
  end

  assign grp = addr_q[15];
  assign row = addr_q[2 +: ADDR_W];

  always_comb begin
    lane_en = 4'h0;
    unique case (1'b1)
      size_q[2] | size_q[1]: lane_en = 4'hF;
      size_q == 3'd1:        lane_en = addr_q[1] ? 4'hC : 4'h3;
      size_q == 3'd0:        lane_en = 4'b0001 << addr_q[1:0];
      default:               lane_en = 4'h0;
    endcase
  end

  assign bist_wr  = (state == S_W55) | (state == S_WAA);
  assign bist_rd  = (state == S_R55) | (state == S_RAA);
  assign bist_pat = ((state == S_WAA) | (state == S_RAA)) ? 8'hAA : 8'h55;

  // BIST owns the port whenever it runs; bus writes only happen in IDLE
  always_ff @(posedge hclk) begin
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 4; k++) begin
        if (bist_wr)
          bank[g*4+k][brow] <= bist_pat;
        else if (wr_q && grp == g[0] && lane_en[k])
          bank[g*4+k][row] <= hwdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 4; k++)
      rd_word[8*k +: 8] = grp ? bank[4+k][row] : bank[k][row];
  end

  always_comb begin
    mism = '0;
    for (int b = 0; b < 8; b++)
      mism[b] = (bank[b][brow] != bist_pat);
  end

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      state     <= S_IDLE;
      brow      <= '0;
      bist_fail <= '0;
    end else if (!bist_en) begin
      state <= S_IDLE;
      brow  <= '0;
    end else begin
      if (bist_rd)
        bist_fail <= bist_fail | mism;
      unique case (state)
        S_IDLE: begin
          state     <= S_W55;
          brow      <= '0;
          bist_fail <= '0;
        end
        S_W55, S_R55, S_WAA, S_RAA: begin
          brow <= brow + 1'b1;
          if (&brow)
            state <= state + 3'd1;
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign hready_resp = idle;
  assign hresp       = 2'b00;
  assign hrdata      = (rd_q & idle & ~dft_en) ? rd_word : 32'h0;
  assign bist_done   = (state == S_DONE);

endmodule

// File: tb/tb_sramc_top.sv
// Randomized bench for sramc_top against a byte-array memory model.
// Built with ADDR_W = 4 so a full BIST pass is short.
module tb_sramc_top;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel, hwrite, hready;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata;
  logic        dft_en, bist_en;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        bist_done;
  logic [7:0]  bist_fail;

  int total = 0;
  int bad = 0;

  logic [7:0] mb [2*DEPTH*4];

  sramc_top #(.ADDR_W(AW)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hwrite(hwrite),
    .hready(hready), .hsize(hsize), .hburst(hburst), .htrans(htrans),
    .haddr(haddr), .hwdata(hwdata), .dft_en(dft_en), .bist_en(bist_en),
    .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata),
    .bist_done(bist_done), .bist_fail(bist_fail)
  );

  always #5 hclk = ~hclk;

  function automatic int widx(input logic [31:0] a);
    return (a[15] ? DEPTH : 0) + int'((a >> 2) % DEPTH);
  endfunction

  function automatic void model_write(input logic [31:0] a,
                                      input logic [2:0] sz,
                                      input logic [31:0] d);
    for (int k = 0; k < 4; k++) begin
      bit en;
      if (sz >= 2) en = 1;
      else if (sz == 1) en = ((k / 2) == int'(a[1]));
      else en = (k == int'(a[1:0]));
      if (en) mb[widx(a)*4 + k] = d[8*k +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = mb[widx(a)*4 + k];
    return r;
  endfunction

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_bus();
    hsel = 0; hwrite = 0; hready = 1; htrans = 2'b00;
    hsize = 3'd2; hburst = 3'd0; haddr = 32'h0;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a,
                            input logic [2:0] sz);
    hsel = 1; hwrite = wr; hready = 1; htrans = 2'b10;
    haddr = a; hsize = sz; hburst = 3'($urandom_range(0, 7));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] d, input bit upd);
    addr_phase(1, a, sz);
    tick();
    idle_bus();
    hwdata = d;
    tick();
    if (upd) model_write(a, sz, d);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] sz,
                         output logic [31:0] d, output logic rdy);
    addr_phase(0, a, sz);
    tick();
    d = hrdata;
    rdy = hready_resp;
    idle_bus();
  endtask

  task automatic test_reset();
    idle_bus();
    hwdata = 0; dft_en = 0; bist_en = 0;
    tick();
    hresetn = 1;
    repeat (5) tick();
    total++;
    if (hready_resp !== 1'b1) begin
      bad++; $display("FAIL reset_hready got=%b exp=1", hready_resp);
    end
    total++;
    if (hresp !== 2'b00) begin
      bad++; $display("FAIL reset_hresp got=%b exp=00", hresp);
    end
    total++;
    if (hrdata !== 32'h0) begin
      bad++; $display("FAIL reset_hrdata got=%h exp=0", hrdata);
    end
    total++;
    if (bist_done !== 1'b0 || bist_fail !== 8'h00) begin
      bad++;
      $display("FAIL reset_bist got=%b/%h exp=0/00", bist_done, bist_fail);
    end
    hresetn = 0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic rdy;
    do_write(32'h1, 3'd2, 32'h000123AF, 1);
    do_read(32'h0, 3'd2, d, rdy);
    total++;
    if (d !== model_read(32'h0) || rdy !== 1'b1) begin
      bad++;
      $display("FAIL basic_word got=%h/%b exp=%h/1", d, rdy,
               model_read(32'h0));
    end
  endtask

  task automatic test_lanes();
    logic [31:0] d;
    logic rdy;
    do_write(32'h10, 3'd2, 32'hFFFFFFFF, 1);
    do_write(32'h12, 3'd0, 32'h00AB0000, 1);
    do_write(32'h10, 3'd1, 32'h00001234, 1);
    do_read(32'h10, 3'd0, d, rdy);
    total++;
    if (d !== model_read(32'h10)) begin
      bad++; $display("FAIL lanes got=%h exp=%h", d, model_read(32'h10));
    end
    do_write(32'h17, 3'd0, 32'h5A000000, 1);
    do_write(32'h16, 3'd1, 32'h9ABC0000, 1);
    do_read(32'h14, 3'd2, d, rdy);
    total++;
    if (d[31:16] !== model_read(32'h14)[31:16]) begin
      bad++;
      $display("FAIL lanes_hi got=%h exp=%h", d, model_read(32'h14));
    end
  endtask

  task automatic test_groups();
    logic [31:0] d, ref0;
    logic rdy;
    do_write(32'h8000, 3'd2, 32'h11223344, 1);
    do_write(32'h0000, 3'd2, 32'hCAFEF00D, 1);
    do_read(32'h8000, 3'd2, d, rdy);
    total++;
    if (d !== model_read(32'h8000)) begin
      bad++; $display("FAIL group1 got=%h exp=%h", d, model_read(32'h8000));
    end
    do_read(32'h0000, 3'd2, d, rdy);
    total++;
    if (d !== model_read(32'h0)) begin
      bad++; $display("FAIL group0 got=%h exp=%h", d, model_read(32'h0));
    end
    do_read(32'h00010000, 3'd2, d, rdy);
    total++;
    if (d !== model_read(32'h0)) begin
      bad++; $display("FAIL alias got=%h exp=%h", d, model_read(32'h0));
    end
    ref0 = model_read(32'h0);
    for (int t = 0; t < 3; t++) begin
      hsel = 1; hwrite = 1; hsize = 3'd2; haddr = 32'h0;
      htrans = (t == 1) ? 2'b01 : 2'b00;
      hready = 1;
      if (t == 2) begin
        htrans = 2'b10; hready = 0;
      end
      tick();
      idle_bus();
      hwdata = 32'hBAD0BAD0;
      tick();
    end
    do_read(32'h0, 3'd2, d, rdy);
    total++;
    if (d !== ref0) begin
      bad++; $display("FAIL idle_busy got=%h exp=%h", d, ref0);
    end
  endtask

  task automatic test_dft();
    logic [31:0] d;
    logic rdy;
    do_write(32'h20, 3'd2, 32'h0BADF00D, 1);
    dft_en = 1;
    do_write(32'h20, 3'd2, 32'hDEADBEEF, 0);
    do_read(32'h20, 3'd2, d, rdy);
    total++;
    if (d !== 32'h0 || rdy !== 1'b1) begin
      bad++; $display("FAIL dft_read got=%h/%b exp=0/1", d, rdy);
    end
    dft_en = 0;
    do_read(32'h20, 3'd2, d, rdy);
    total++;
    if (d !== model_read(32'h20)) begin
      bad++; $display("FAIL dft_keep got=%h exp=%h", d, model_read(32'h20));
    end
  endtask

  task automatic test_random();
    logic [31:0] d, a;
    logic [2:0] sz;
    logic rdy;
    for (int g = 0; g < 2; g++)
      for (int r = 0; r < DEPTH; r++)
        do_write(32'(g * 32'h8000 + r * 4), 3'd2, $urandom, 1);
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      sz = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, sz, $urandom, 1);
      end else begin
        do_read(a, sz, d, rdy);
        total++;
        if (d !== model_read(a) || rdy !== 1'b1 || hresp !== 2'b00) begin
          bad++;
          $display("FAIL rand_read a=%h got=%h exp=%h rdy=%b", a, d,
                   model_read(a), rdy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, a2, d1, d2, d;
    logic rdy;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      d1 = $urandom;
      addr_phase(1, a, 3'($urandom_range(0, 2)));
      model_write(a, hsize, d1);
      tick();
      addr_phase(0, {a[31:2], 2'($urandom)}, 3'($urandom_range(0, 2)));
      hwdata = d1;
      tick();
      total++;
      if (hrdata !== model_read(a) || hready_resp !== 1'b1) begin
        bad++;
        $display("FAIL b2b_wr_rd a=%h got=%h exp=%h", a, hrdata,
                 model_read(a));
      end
      idle_bus();
    end
    a = 32'h8004;
    a2 = 32'h8008;
    d1 = $urandom;
    d2 = $urandom;
    addr_phase(1, a, 3'd2);
    tick();
    addr_phase(1, a2, 3'd2);
    hwdata = d1;
    tick();
    idle_bus();
    hwdata = d2;
    tick();
    model_write(a, 3'd2, d1);
    model_write(a2, 3'd2, d2);
    do_read(a, 3'd2, d, rdy);
    total++;
    if (d !== model_read(a)) begin
      bad++; $display("FAIL b2b_wr1 got=%h exp=%h", d, model_read(a));
    end
    do_read(a2, 3'd2, d, rdy);
    total++;
    if (d !== model_read(a2)) begin
      bad++; $display("FAIL b2b_wr2 got=%h exp=%h", d, model_read(a2));
    end
  endtask

  task automatic test_bist();
    int n;
    logic [31:0] d, a;
    logic rdy;
    bit busy_ok;
    idle_bus();
    bist_en = 1;
    n = 0;
    busy_ok = 1;
    while (!bist_done && n < 200) begin
      addr_phase(1, 32'h0, 3'd2);
      hwdata = 32'h12345678;
      tick();
      n++;
      if (!bist_done && (hready_resp !== 1'b0 || hrdata !== 32'h0))
        busy_ok = 0;
    end
    idle_bus();
    total++;
    if (n != 4 * DEPTH + 1) begin
      bad++; $display("FAIL bist_len got=%0d exp=%0d", n, 4 * DEPTH + 1);
    end
    total++;
    if (!busy_ok) begin
      bad++; $display("FAIL bist_busy hready/hrdata not blocked in run");
    end
    total++;
    if (bist_fail !== 8'h00 || bist_done !== 1'b1) begin
      bad++;
      $display("FAIL bist_res got=%b/%h exp=1/00", bist_done, bist_fail);
    end
    tick();
    bist_en = 0;
    tick();
    total++;
    if (bist_done !== 1'b0 || hready_resp !== 1'b1) begin
      bad++;
      $display("FAIL bist_exit got=%b/%b exp=0/1", bist_done, hready_resp);
    end
    for (int i = 0; i < 2*DEPTH*4; i++) mb[i] = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      do_read(a, 3'd2, d, rdy);
      total++;
      if (d !== model_read(a)) begin
        bad++; $display("FAIL bist_mem a=%h got=%h exp=%h", a, d,
                        model_read(a));
      end
    end
  endtask

  task automatic test_bist_abort();
    bist_en = 1;
    repeat (10) tick();
    total++;
    if (hready_resp !== 1'b0) begin
      bad++; $display("FAIL abort_run got=%b exp=0", hready_resp);
    end
    hresetn = 1;
    bist_en = 0;
    tick();
    total++;
    if (bist_done !== 1'b0 || hready_resp !== 1'b1 || bist_fail !== 8'h0) begin
      bad++;
      $display("FAIL abort_rst got=%b/%b/%h exp=0/1/00", bist_done,
               hready_resp, bist_fail);
    end
    hresetn = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_groups();
    test_dft();
    test_random();
    test_back_to_back();
    test_bist();
    test_bist_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
